// File: rtl/pme_agg_pkg.sv
// Shared types and constants for the PME aggregator.
// Covers the FSM state encoding, the channel-ID width helper and the default resend interval.
package pme_agg_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_e;

   localparam int DEF_TIMEOUT = 255;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pme_rr_arb.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i and wraps; the outputs are a one-hot grant and a binary ID.
module pme_rr_arb
   import pme_agg_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ID_W   = id_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [ID_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [ID_W-1:0]   id_o
);

   int   idx;
   logic found;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      idx   = 0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr_i) + i) % NUM_CH;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            id_o       = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/pme_aggregator.sv
// Multi-channel PME collector: sticky status, round-robin message stream, optional resend.
// Defining PME_AGG_RESEND_EN enables the timer that re-signals unacknowledged (uncleared) events.
module pme_aggregator
   import pme_agg_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int ID_W    = id_width(NUM_CH),
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] pme_i,
   input  logic [NUM_CH-1:0] pme_en_i,
   input  logic [NUM_CH-1:0] clr_i,
   output logic              msg_valid_o,
   input  logic              msg_ready_i,
   output logic [ID_W-1:0]   msg_id_o,
   output logic [NUM_CH-1:0] pme_status_o,
   output logic              pme_pend_o
);

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [NUM_CH-1:0] status_q, status_d;
   logic [NUM_CH-1:0] sent_q, sent_d;
   logic [NUM_CH-1:0] sent_set;
   logic [NUM_CH-1:0] cand;
   logic [NUM_CH-1:0] unused_gnt;
   logic [ID_W-1:0]   arb_id;
   logic              expire;

   assign cand = status_q & ~sent_q;

   pme_rr_arb #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_arb (
      .req_i  (cand),
      .ptr_i  (ptr_q),
      .gnt_o  (unused_gnt),
      .id_o   (arb_id)
   );

`ifdef PME_AGG_RESEND_EN
   logic [CNT_W-1:0] timer_q, timer_d;

   // Timer only runs while some delivered event is still uncleared.
   always_comb begin
      expire  = 1'b0;
      timer_d = timer_q;
      if (!(|(status_q & sent_q))) begin
         timer_d = '0;
      end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
         timer_d = '0;
         expire  = 1'b1;
      end else begin
         timer_d = timer_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end
`else
   localparam int unused_cfg = TIMEOUT + CNT_W;
   assign expire = 1'b0;
`endif

   always_comb begin
      status_d = (status_q & ~clr_i) | (pme_i & pme_en_i);
      state_d  = state_q;
      valid_d  = valid_q;
      id_d     = id_q;
      ptr_d    = ptr_q;
      sent_set = '0;
      case (state_q)
         ST_IDLE: begin
            if (|cand) begin
               state_d = ST_SEND;
               valid_d = 1'b1;
               id_d    = arb_id;
            end
         end
         ST_SEND: begin
            if (msg_ready_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               ptr_d   = (id_q == ID_W'(NUM_CH - 1)) ? '0 : id_q + ID_W'(1);
               if (status_q[id_q]) sent_set[id_q] = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A clear drops the delivered mark so a same-cycle re-trigger is announced again.
      sent_d = ((expire ? '0 : sent_q) | sent_set) & ~clr_i & status_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         id_q     <= '0;
         ptr_q    <= '0;
         status_q <= '0;
         sent_q   <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         id_q     <= id_d;
         ptr_q    <= ptr_d;
         status_q <= status_d;
         sent_q   <= sent_d;
      end
   end

   assign msg_valid_o  = valid_q;
   assign msg_id_o     = id_q;
   assign pme_status_o = status_q;
   assign pme_pend_o   = |status_q;

endmodule

// File: tb/tb_pme_aggregator.sv
// Directed self-checking bench for pme_aggregator (4 channels, resend interval 16).
module tb_pme_aggregator;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pme_i, pme_en_i, clr_i;
   logic       msg_valid_o, msg_ready_i;
   logic [1:0] msg_id_o;
   logic [3:0] pme_status_o;
   logic       pme_pend_o;

   int n_cmp = 0;
   int n_err = 0;

   pme_aggregator #(
      .NUM_CH  (4),
      .TIMEOUT (16),
      .CNT_W   (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pme_i        (pme_i),
      .pme_en_i     (pme_en_i),
      .clr_i        (clr_i),
      .msg_valid_o  (msg_valid_o),
      .msg_ready_i  (msg_ready_i),
      .msg_id_o     (msg_id_o),
      .pme_status_o (pme_status_o),
      .pme_pend_o   (pme_pend_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pme_i = '0; pme_en_i = 4'hF; clr_i = '0; msg_ready_i = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic clear_all();
      clr_i = 4'hF;
      tick();
      clr_i = '0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (msg_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", msg_valid_o); end
      n_cmp++; if (msg_id_o !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", msg_id_o); end
      n_cmp++; if (pme_status_o !== 4'b0000) begin n_err++; $display("FAIL rst_status: got %b want 0000", pme_status_o); end
      n_cmp++; if (pme_pend_o !== 1'b0) begin n_err++; $display("FAIL rst_pend: got %b want 0", pme_pend_o); end
   endtask

   task automatic test_single();
      int nmsg;
      pme_i = 4'b0100;
      tick();
      pme_i = '0;
      n_cmp++; if (pme_status_o !== 4'b0100) begin n_err++; $display("FAIL single_status: got %b want 0100", pme_status_o); end
      n_cmp++; if (pme_pend_o !== 1'b1) begin n_err++; $display("FAIL single_pend: got %b want 1", pme_pend_o); end
      n_cmp++; if (msg_valid_o !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", msg_valid_o); end
      tick();
      n_cmp++; if (msg_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", msg_valid_o); end
      n_cmp++; if (msg_id_o !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", msg_id_o); end
      nmsg = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (msg_valid_o) nmsg++;
      end
      n_cmp++; if (nmsg !== 0) begin n_err++; $display("FAIL single_extra_msgs: got %0d want 0", nmsg); end
      n_cmp++; if (pme_status_o !== 4'b0100) begin n_err++; $display("FAIL single_sticky: got %b want 0100", pme_status_o); end
      clr_i = 4'b0100;
      tick();
      clr_i = '0;
      n_cmp++; if (pme_status_o !== 4'b0000) begin n_err++; $display("FAIL single_clear: got %b want 0000", pme_status_o); end
   endtask

   task automatic test_back_to_back();
      int ids[$];
      int cyc[$];
      do_reset();
      pme_i = 4'b1011;
      tick();
      pme_i = '0;
      for (int c = 2; c <= 10; c++) begin
         tick();
         if (msg_valid_o) begin ids.push_back(int'(msg_id_o)); cyc.push_back(c); end
      end
      n_cmp++; if (ids.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", ids.size()); end
      if (ids.size() == 3) begin
         n_cmp++; if (ids[0] !== 0 || ids[1] !== 1 || ids[2] !== 3) begin
            n_err++; $display("FAIL b2b_order: got %0d,%0d,%0d want 0,1,3", ids[0], ids[1], ids[2]);
         end
         n_cmp++; if (cyc[0] !== 2 || cyc[1] !== 4 || cyc[2] !== 6) begin
            n_err++; $display("FAIL b2b_timing: got %0d,%0d,%0d want 2,4,6", cyc[0], cyc[1], cyc[2]);
         end
      end
      n_cmp++; if (pme_status_o !== 4'b1011) begin n_err++; $display("FAIL b2b_status: got %b want 1011", pme_status_o); end
      clear_all();
   endtask

   task automatic test_backpressure();
      int good;
      msg_ready_i = 1'b0;
      pme_i = 4'b0010;
      tick();
      pme_i = '0;
      tick();
      good = 0;
      for (int i = 0; i < 10; i++) begin
         if (msg_valid_o && msg_id_o == 2'd1) good++;
         clr_i = (i == 5) ? 4'b0010 : 4'b0000;
         tick();
      end
      clr_i = '0;
      n_cmp++; if (good !== 10) begin n_err++; $display("FAIL bp_hold: got %0d stable cycles want 10", good); end
      n_cmp++; if (msg_valid_o !== 1'b1 || msg_id_o !== 2'd1) begin
         n_err++; $display("FAIL bp_after_clr: got valid=%b id=%0d want valid=1 id=1", msg_valid_o, msg_id_o);
      end
      n_cmp++; if (pme_status_o[1] !== 1'b0) begin n_err++; $display("FAIL bp_status1: got %b want 0", pme_status_o[1]); end
      msg_ready_i = 1'b1;
      tick();
      n_cmp++; if (msg_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_complete: got %b want 0", msg_valid_o); end
      good = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (msg_valid_o) good++;
      end
      n_cmp++; if (good !== 0) begin n_err++; $display("FAIL bp_no_repeat: got %0d msgs want 0", good); end
   endtask

   task automatic test_set_clear_enable();
      int nmsg;
      int id0;
      pme_en_i = 4'b1011;
      pme_i = 4'b0101;
      clr_i = 4'b0001;
      tick();
      pme_i = '0; clr_i = '0;
      n_cmp++; if (pme_status_o !== 4'b0001) begin n_err++; $display("FAIL setclr_status: got %b want 0001", pme_status_o); end
      nmsg = 0; id0 = -1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (msg_valid_o) begin nmsg++; id0 = int'(msg_id_o); end
      end
      n_cmp++; if (nmsg !== 1 || id0 !== 0) begin n_err++; $display("FAIL setclr_msg: got %0d msgs id %0d want 1 msg id 0", nmsg, id0); end
      n_cmp++; if (pme_status_o[2] !== 1'b0) begin n_err++; $display("FAIL disabled_ch: got %b want 0", pme_status_o[2]); end
      pme_i = 4'b1000;
      tick();
      pme_i = '0;
      pme_en_i = 4'b0000;
      tick(); tick();
      n_cmp++; if (pme_status_o !== 4'b1001) begin n_err++; $display("FAIL en_off_keeps: got %b want 1001", pme_status_o); end
      pme_en_i = 4'hF;
      clear_all();
      tick();
   endtask

`ifdef PME_AGG_RESEND_EN
   task automatic test_resend();
      int gap, nmsg;
      do_reset();
      pme_i = 4'b1000;
      tick();
      pme_i = '0;
      tick();
      n_cmp++; if (msg_valid_o !== 1'b1 || msg_id_o !== 2'd3) begin
         n_err++; $display("FAIL rs_first: got valid=%b id=%0d want valid=1 id=3", msg_valid_o, msg_id_o);
      end
      gap = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (msg_valid_o && gap < 0) gap = i;
      end
      n_cmp++; if (gap !== 18) begin n_err++; $display("FAIL rs_gap: got %0d want 18", gap); end
      clear_all();
      pme_i = 4'b1000;
      tick();
      pme_i = '0;
      for (int i = 0; i < 6; i++) tick();
      clear_all();
      nmsg = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (msg_valid_o) nmsg++;
      end
      n_cmp++; if (nmsg !== 0) begin n_err++; $display("FAIL rs_cleared: got %0d msgs want 0", nmsg); end
   endtask
`else
   task automatic test_no_resend();
      int nmsg;
      do_reset();
      pme_i = 4'b1000;
      tick();
      pme_i = '0;
      nmsg = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (msg_valid_o) nmsg++;
      end
      n_cmp++; if (nmsg !== 1) begin n_err++; $display("FAIL nors_count: got %0d msgs want 1", nmsg); end
      n_cmp++; if (pme_status_o !== 4'b1000) begin n_err++; $display("FAIL nors_status: got %b want 1000", pme_status_o); end
      clear_all();
   endtask
`endif

   task automatic test_reset_in_send();
      msg_ready_i = 1'b0;
      pme_i = 4'b0001;
      tick();
      pme_i = '0;
      tick();
      n_cmp++; if (msg_valid_o !== 1'b1) begin n_err++; $display("FAIL rsend_pre: got %b want 1", msg_valid_o); end
      rst = 1'b1;
      tick();
      n_cmp++; if (msg_valid_o !== 1'b0) begin n_err++; $display("FAIL rsend_valid: got %b want 0", msg_valid_o); end
      n_cmp++; if (pme_status_o !== 4'b0000 || pme_pend_o !== 1'b0) begin
         n_err++; $display("FAIL rsend_status: got %b pend=%b want 0000 pend=0", pme_status_o, pme_pend_o);
      end
      rst = 1'b0;
      msg_ready_i = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      pme_i = '0; pme_en_i = 4'hF; clr_i = '0; msg_ready_i = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_set_clear_enable();
`ifdef PME_AGG_RESEND_EN
      test_resend();
`else
      test_no_resend();
`endif
      test_reset_in_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
